fdiv_iter: RTL and testbench

//  Iterative IEEE-754 single-precision divider, y = x1 / x2; the inverse operation of the pipelined fmul.

---
 rtl/fdiv_iter.sv | 165 ++++++++++++++++
 tb/tb_fdiv_iter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_iter.sv
// Iterative single-precision divider, y = x1 / x2.
// Restoring radix-2 mantissa division producing one quotient bit per clock,
// followed by a single normalise/round/pack cycle. Fixed latency regardless of operands.
// States:
//   state | meaning
//   IDLE  | ready for a new operand pair
//   DIV   | one quotient bit per cycle, QBITS cycles
//   NORM  | special-case decode, normalise, round, pack, pulse valid_out
module fdiv_iter #(
   parameter int          QBITS     = 26,
   parameter logic [31:0] CANON_NAN = 32'h7FC0_0000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   input  logic        valid_in,
   output logic        ready,
   output logic [31:0] y,
   output logic        valid_out
);

   typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;

   state_t             state_q, state_d;
   logic [31:0]        a_q, a_d;
   logic [31:0]        b_q, b_d;
   logic [24:0]        rem_q, rem_d;
   logic [QBITS-1:0]   q_q, q_d;
   logic [4:0]         cnt_q, cnt_d;
   logic [31:0]        y_q, y_d;
   logic               vout_q, vout_d;

   logic [24:0]        div_ext;
   logic [24:0]        rem_sub;
   logic [24:0]        rem_sel;
   logic               q_bit;

   logic               sign;
   logic               nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
   logic signed [9:0]  exp_diff;
   logic signed [9:0]  exp_n;
   logic signed [9:0]  exp_r;
   logic [23:0]        mant;
   logic               guard, sticky, rnd;
   logic [24:0]        mant_r;
   logic [22:0]        frac_r;
   logic [31:0]        result;

   assign ready     = (state_q == IDLE);
   assign y         = y_q;
   assign valid_out = vout_q;

   // One restoring step: subtract the divisor when it fits, then shift the partial remainder.
   always_comb begin
      div_ext = {2'b01, b_q[22:0]};
      rem_sub = rem_q - div_ext;
      q_bit   = (rem_q >= div_ext);
      rem_sel = q_bit ? rem_sub : rem_q;
   end

   // Classification, normalisation, RNE rounding and packing of the finished quotient.
   always_comb begin
      sign   = a_q[31] ^ b_q[31];
      zero_a = (a_q[30:23] == 8'd0);
      zero_b = (b_q[30:23] == 8'd0);
      inf_a  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
      inf_b  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
      nan_a  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
      nan_b  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);

      exp_diff = signed'({2'b00, a_q[30:23]}) - signed'({2'b00, b_q[30:23]});
      // Quotient lies in (0.5, 2): the top bit picks the binade.
      if (q_q[QBITS-1]) begin
         mant   = q_q[QBITS-1:2];
         guard  = q_q[1];
         sticky = q_q[0] | (|rem_q);
         exp_n  = exp_diff + 10'sd127;
      end else begin
         mant   = q_q[QBITS-2:1];
         guard  = q_q[0];
         sticky = |rem_q;
         exp_n  = exp_diff + 10'sd126;
      end

      rnd    = guard & (sticky | mant[0]);
      mant_r = {1'b0, mant} + {24'd0, rnd};
      exp_r  = mant_r[24] ? exp_n + 10'sd1 : exp_n;
      frac_r = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

      if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b))
         result = CANON_NAN;
      else if (inf_a || zero_b)
         result = {sign, 31'h7F80_0000};
      else if (inf_b || zero_a)
         result = {sign, 31'd0};
      else if (exp_r >= 10'sd255)
         result = {sign, 31'h7F80_0000};
      else if (exp_r <= 10'sd0)
         result = {sign, 31'd0};
      else
         result = {sign, exp_r[7:0], frac_r};
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      vout_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (valid_in) begin
               // Subnormals become signed zero before anything else looks at them.
               a_d     = (x1[30:23] == 8'd0) ? {x1[31], 31'd0} : x1;
               b_d     = (x2[30:23] == 8'd0) ? {x2[31], 31'd0} : x2;
               rem_d   = {2'b01, x1[22:0]};
               q_d     = '0;
               cnt_d   = 5'(QBITS - 1);
               state_d = DIV;
            end
         end
         DIV: begin
            rem_d = rem_sel << 1;
            q_d   = {q_q[QBITS-2:0], q_bit};
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd0) state_d = NORM;
         end
         NORM: begin
            y_d     = result;
            vout_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         y_q     <= '0;
         vout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         vout_q  <= vout_d;
      end
   end

endmodule

// File: tb/tb_fdiv_iter.sv
// Scoreboard bench for fdiv_iter: the driver pushes expected results, the monitor
// pops and checks them whenever valid_out pulses, including the fixed latency.
module tb_fdiv_iter;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] x1, x2;
   logic        valid_in;
   logic        ready;
   logic [31:0] y;
   logic        valid_out;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   // kind 0: exact bits, 1: within 2 ulp of q, 2: exact bits (overflow), 3: not value-checked
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] e;
      int          kind;
      real         q;
      int          acc;
   } exp_t;

   exp_t sb[$];

   fdiv_iter dut (
      .clk       (clk),
      .rstn      (rstn),
      .x1        (x1),
      .x2        (x2),
      .valid_in  (valid_in),
      .ready     (ready),
      .y         (y),
      .valid_out (valid_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:23] == 8'd0) return 0.0;
      d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic real ulp_of(input logic [31:0] f);
      logic [63:0] d;
      d = {1'b0, 11'(int'(f[30:23]) - 150 + 1023), 52'd0};
      return $bitstoreal(d);
   endfunction

   // Monitor: compare every output pulse against the oldest expectation.
   always @(posedge clk) begin
      exp_t e;
      real  diff;
      logic ok;
      #1;
      if (valid_out) begin
         if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_valid_out: got y=%h, required no output", y);
         end else begin
            e = sb.pop_front();
            chk("latency", 32'(cyc - e.acc), 32'd27);
            if (e.kind == 0 || e.kind == 2) begin
               chk("result", y, e.e);
            end else if (e.kind == 1) begin
               checks++;
               ok = (y[30:23] != 8'd0) && (y[30:23] != 8'hFF);
               if (ok) begin
                  diff = f2r(y) - e.q;
                  if (diff < 0.0) diff = -diff;
                  ok = diff < 2.0 * ulp_of(y);
               end
               if (!ok) begin
                  fails++;
                  $display("FAIL rand_tol: x1=%h x2=%h got %h, required %g within 2 ulp",
                           e.a, e.b, y, e.q);
               end
            end
         end
      end
   end

   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e,
                       input int kind, input real q);
      exp_t t;
      t.a = a; t.b = b; t.e = e; t.kind = kind; t.q = q; t.acc = cyc + 1;
      sb.push_back(t);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!ready) begin
         checks++;
         fails++;
         $display("FAIL ready_timeout: got ready=0, required 1");
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e,
                        input int kind, input real q);
      @(negedge clk);
      wait_ready();
      x1 = a; x2 = b; valid_in = 1'b1;
      push(a, b, e, kind, q);
      @(negedge clk);
      valid_in = 1'b0;
   endtask

   // From the negedge after an accept, count busy cycles until ready returns.
   task automatic count_busy(output int n);
      n = 0;
      while (!ready && n < 60) begin
         @(negedge clk);
         n++;
      end
   endtask

   logic [31:0] hv_a [3] = '{32'h40C0_0000, 32'h3F80_0000, 32'h4120_0000};
   logic [31:0] hv_b [3] = '{32'h4000_0000, 32'h4040_0000, 32'h40A0_0000};
   logic [31:0] hv_e [3] = '{32'h4040_0000, 32'h3EAA_AAAB, 32'h4000_0000};

   logic [31:0] dv_a [9] = '{32'hBF80_0000, 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000,
                             32'h7FC0_0001, 32'h0040_0000, 32'h7F00_0000, 32'h0080_0000,
                             32'hC0C0_0000};
   logic [31:0] dv_b [9] = '{32'h4040_0000, 32'h0000_0000, 32'h0000_0000, 32'h7F80_0000,
                             32'h3F80_0000, 32'h3F80_0000, 32'h0080_0000, 32'h7F00_0000,
                             32'h4000_0000};
   logic [31:0] dv_e [9] = '{32'hBEAA_AAAB, 32'h7F80_0000, 32'h7FC0_0000, 32'h7FC0_0000,
                             32'h7FC0_0000, 32'h0000_0000, 32'h7F80_0000, 32'h0000_0000,
                             32'hC040_0000};

   initial begin
      int          nb;
      int          prev_acc;
      int          guard_cnt;
      logic [31:0] a, b;
      real         q, aq;
      rstn = 1'b0; valid_in = 1'b0; x1 = '0; x2 = '0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      chk("reset_ready", 32'(ready), 32'd1);
      chk("reset_y", y, 32'd0);
      chk("reset_valid_out", 32'(valid_out), 32'd0);

      // 6/2 with busy-window check
      issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0, 0.0);
      count_busy(nb);
      chk("busy_cycles_6_2", 32'(nb), 32'd27);

      issue(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 0, 0.0);
      for (int i = 0; i < 9; i++) issue(dv_a[i], dv_b[i], dv_e[i], 0, 0.0);

      // valid_in held high; operands scrambled while busy
      @(negedge clk);
      wait_ready();
      valid_in = 1'b1;
      prev_acc = 0;
      for (int k = 0; k < 3; k++) begin
         x1 = hv_a[k]; x2 = hv_b[k];
         push(hv_a[k], hv_b[k], hv_e[k], 0, 0.0);
         if (k > 0) chk("issue_interval", 32'(cyc + 1 - prev_acc), 32'd28);
         prev_acc = cyc + 1;
         @(negedge clk);
         x1 = 32'h7FC0_0000; x2 = 32'h0000_0000;
         if (k == 2) valid_in = 1'b0;
         count_busy(nb);
         chk("busy_cycles_held", 32'(nb), 32'd27);
      end

      // reset in the middle of a divide
      @(negedge clk);
      wait_ready();
      x1 = 32'h40C0_0000; x2 = 32'h4000_0000; valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      repeat (10) @(negedge clk);
      chk("midop_busy", 32'(ready), 32'd0);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      chk("midop_reset_ready", 32'(ready), 32'd1);
      chk("midop_reset_y", y, 32'd0);
      chk("midop_reset_valid_out", 32'(valid_out), 32'd0);
      repeat (40) @(negedge clk);
      issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0, 0.0);

      // random regression against real-valued division
      for (int i = 0; i < 1024; i++) begin
         a = $urandom;
         b = $urandom;
         a[30:23] = 8'($urandom_range(64, 190));
         b[30:23] = 8'($urandom_range(64, 190));
         q  = f2r(a) / f2r(b);
         aq = (q < 0.0) ? -q : q;
         if (aq >= 3.402823669209385e38)
            issue(a, b, {a[31] ^ b[31], 31'h7F80_0000}, 2, q);
         else if (aq >= 3.4028234e38 || aq < 1.2e-38)
            issue(a, b, 32'd0, 3, q);
         else
            issue(a, b, 32'd0, 1, q);
      end

      guard_cnt = 0;
      while (sb.size() != 0 && guard_cnt < 100) begin
         @(negedge clk);
         guard_cnt++;
      end
      if (sb.size() != 0) begin
         checks++;
         fails++;
         $display("FAIL drain: got %0d pending results, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
